// File: rtl/stack_cpu_controller.sv
// Multicycle Moore controller for the 8-bit stack-machine datapath.
// Walks a fixed state sequence per opcode; every strobe is a decode of the state register.
module stack_cpu_controller #(
  parameter int OPC_W   = 3,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         inst,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               pcSrc,
  output logic               IorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               IrWrite,
  output logic               MtoS,
  output logic               ldA,
  output logic               ldB,
  output logic               srcA,
  output logic               srcB,
  output logic               push,
  output logic               pop,
  output logic               tos,
  output logic [ALUOP_W-1:0] AluOp
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_POPA   = 4'd2,
    S_POPB   = 4'd3,
    S_EXEC   = 4'd4,
    S_PUSHR  = 4'd5,
    S_MEMRD  = 4'd6,
    S_PUSHM  = 4'd7,
    S_MEMWR  = 4'd8,
    S_JMP    = 4'd9,
    S_JZTOS  = 4'd10,
    S_JZ     = 4'd11
  } state_t;

  localparam logic [OPC_W-1:0] OP_NOT  = 3'b011;
  localparam logic [OPC_W-1:0] OP_PUSH = 3'b100;
  localparam logic [OPC_W-1:0] OP_POP  = 3'b101;
  localparam logic [OPC_W-1:0] OP_JMP  = 3'b110;
  localparam logic [OPC_W-1:0] OP_JZ   = 3'b111;

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;

  // The address field is consumed by the datapath through IR, not here.
  logic unused_addr;
  assign unused_addr = ^inst[7-OPC_W:0];

  // State and opcode registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  // Next-state logic; the opcode copy is only refreshed while fetching.
  always_comb begin
    state_d = S_FETCH;
    opc_d   = opc_q;
    case (state_q)
      S_FETCH: begin
        opc_d   = inst[7:8-OPC_W];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opc_q)
          OP_PUSH: state_d = S_MEMRD;
          OP_JMP:  state_d = S_JMP;
          OP_JZ:   state_d = S_JZTOS;
          default: state_d = S_POPA;
        endcase
      end
      S_POPA: begin
        if (opc_q == OP_NOT) begin
          state_d = S_EXEC;
        end else if (opc_q == OP_POP) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_POPB;
        end
      end
      S_POPB:  state_d = S_EXEC;
      S_EXEC:  state_d = S_PUSHR;
      S_PUSHR: state_d = S_FETCH;
      S_MEMRD: state_d = S_PUSHM;
      S_PUSHM: state_d = S_FETCH;
      S_MEMWR: state_d = S_FETCH;
      S_JMP:   state_d = S_FETCH;
      S_JZTOS: state_d = S_JZ;
      S_JZ:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobe decode of the current state; reset forces every strobe low in the same cycle.
  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    pcSrc       = 1'b0;
    IorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    IrWrite     = 1'b0;
    MtoS        = 1'b0;
    ldA         = 1'b0;
    ldB         = 1'b0;
    srcA        = 1'b0;
    srcB        = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    tos         = 1'b0;
    AluOp       = '0;
    if (rst) begin
      pcWrite = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          memRead = 1'b1;
          IrWrite = 1'b1;
          srcA    = 1'b1;
          srcB    = 1'b1;
          pcWrite = 1'b1;
        end
        S_POPA: begin
          tos = 1'b1;
          pop = 1'b1;
          ldA = 1'b1;
        end
        S_POPB: begin
          tos = 1'b1;
          pop = 1'b1;
          ldB = 1'b1;
        end
        S_EXEC:  AluOp = opc_q[ALUOP_W-1:0];
        S_PUSHR: push = 1'b1;
        S_MEMRD: begin
          IorD    = 1'b1;
          memRead = 1'b1;
        end
        S_PUSHM: begin
          MtoS = 1'b1;
          push = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          memWrite = 1'b1;
        end
        S_JMP: begin
          pcSrc   = 1'b1;
          pcWrite = 1'b1;
        end
        S_JZTOS: tos = 1'b1;
        S_JZ: begin
          pcSrc       = 1'b1;
          pcWriteCond = 1'b1;
        end
        default: pcWrite = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Scoreboard bench for stack_cpu_controller: an instruction-level model queues the
// expected strobe vector of every cycle; a negedge monitor pops and compares.
module tb_stack_cpu_controller;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mtos;
    logic       ld_a;
    logic       ld_b;
    logic       src_a;
    logic       src_b;
    logic       push;
    logic       pop;
    logic       tos;
    logic [1:0] alu_op;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] inst = 8'h00;
  logic       pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IrWrite, MtoS;
  logic       ldA, ldB, srcA, srcB, push, pop, tos;
  logic [1:0] AluOp;

  out_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  stack_cpu_controller dut (
    .clk(clk), .rst(rst), .inst(inst),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc), .IorD(IorD),
    .memRead(memRead), .memWrite(memWrite), .IrWrite(IrWrite), .MtoS(MtoS),
    .ldA(ldA), .ldB(ldB), .srcA(srcA), .srcB(srcB),
    .push(push), .pop(pop), .tos(tos), .AluOp(AluOp)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle with a queued expectation is compared at the falling edge.
  always @(negedge clk) begin
    out_t  act;
    out_t  e;
    string nm;
    act = '{pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IrWrite, MtoS,
            ldA, ldB, srcA, srcB, push, pop, tos, AluOp};
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %017b expected %017b", nm, act, e);
      end
      n_checks++;
      if ((act.push && act.pop) || (act.mem_read && act.mem_write)) begin
        n_fail++;
        $display("FAIL %s exclusive strobes: got %017b expected no push&pop / rd&wr", nm, act);
      end
    end
  end

  // One clock of stimulus, with the strobe vector the model expects for that cycle.
  task automatic cycle(input logic r, input logic [7:0] w, input out_t e, input string nm);
    @(posedge clk);
    #1;
    rst  = r;
    inst = w;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Instruction-level model: lists the micro-steps of the opcode, then plays them.
  // abort_at >= 0 raises reset during that step, which must blank all strobes.
  task automatic issue(input logic [7:0] word, input int abort_at, input string tag);
    out_t        steps[$];
    out_t        s;
    logic [2:0]  op;
    logic [7:0]  w;
    op = word[7:5];
    s = '0; s.mem_read = 1'b1; s.ir_write = 1'b1; s.src_a = 1'b1; s.src_b = 1'b1;
    s.pc_write = 1'b1;
    steps.push_back(s);
    steps.push_back(out_t'(0));
    if (op < 3'd4) begin
      s = '0; s.tos = 1'b1; s.pop = 1'b1; s.ld_a = 1'b1; steps.push_back(s);
      if (op != 3'd3) begin
        s = '0; s.tos = 1'b1; s.pop = 1'b1; s.ld_b = 1'b1; steps.push_back(s);
      end
      s = '0; s.alu_op = op[1:0]; steps.push_back(s);
      s = '0; s.push = 1'b1; steps.push_back(s);
    end else if (op == 3'd4) begin
      s = '0; s.iord = 1'b1; s.mem_read = 1'b1; steps.push_back(s);
      s = '0; s.mtos = 1'b1; s.push = 1'b1; steps.push_back(s);
    end else if (op == 3'd5) begin
      s = '0; s.tos = 1'b1; s.pop = 1'b1; s.ld_a = 1'b1; steps.push_back(s);
      s = '0; s.iord = 1'b1; s.mem_write = 1'b1; steps.push_back(s);
    end else if (op == 3'd6) begin
      s = '0; s.pc_src = 1'b1; s.pc_write = 1'b1; steps.push_back(s);
    end else begin
      s = '0; s.tos = 1'b1; steps.push_back(s);
      s = '0; s.pc_src = 1'b1; s.pc_write_cond = 1'b1; steps.push_back(s);
    end
    for (int i = 0; i < steps.size(); i++) begin
      w = (i == 0) ? word : 8'($urandom);
      if (i == abort_at) begin
        cycle(1'b1, w, out_t'(0), $sformatf("%s abort step%0d", tag, i));
        break;
      end
      cycle(1'b0, w, steps[i], $sformatf("%s op%0d step%0d", tag, op, i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ab;
    // Reset held for three cycles: everything quiet.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, out_t'(0), "reset");
    // Directed instructions.
    issue(8'h20, -1, "sub");
    issue(8'h85, -1, "push5");
    issue(8'hA3, -1, "pop3");
    issue(8'h6A, -1, "not");
    issue(8'hC9, -1, "jmp");
    issue(8'hE9, -1, "jz");
    issue(8'h00, 3, "add_abort_popb");
    issue(8'h40, -1, "and");
    issue(8'h11, -1, "add");
    // Randomized instruction stream with occasional aborts.
    for (int n = 0; n < 120; n++) begin
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
      issue(8'($urandom), ab, "rnd");
    end
    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
